// File: rtl/conv1d_pkg.sv
// Shared types and defaults for the 1-D convolution sequencer.
// Holds the controller state enum and the tap one-hot helper.
package conv1d_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int PSUM_WIDTH = 16;
  localparam int LEN_WIDTH  = 10;
  localparam int MAX_K      = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } ctrl_state_t;

  // Wide enough for any supported tap count; callers slice to K.
  function automatic logic [MAX_K-1:0] onehot_k(
    input logic [LEN_WIDTH-1:0] idx
  );
    logic [MAX_K-1:0] one;
    one = {{(MAX_K-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/conv1d_seq_ctrl_if.sv
// Stream, PE-array and result bundle of the conv1d sequencer.
// The controller uses master; the array/source/sink side uses slave.
interface conv1d_seq_ctrl_if #(
  parameter int DATA_WIDTH = conv1d_pkg::DATA_WIDTH,
  parameter int PSUM_WIDTH = conv1d_pkg::PSUM_WIDTH,
  parameter int K          = 3
);

  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic [K-1:0]          w_load;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  arr_en;
  logic                  arr_valid;
  logic [DATA_WIDTH-1:0] arr_data;
  logic                  arr_psum_valid;
  logic [PSUM_WIDTH-1:0] arr_psum;
  logic                  m_valid;
  logic                  m_ready;
  logic [PSUM_WIDTH-1:0] m_data;

  modport master (
    input  s_valid, s_data,
    input  arr_psum_valid, arr_psum,
    input  m_ready,
    output s_ready, w_load, w_data,
    output arr_en, arr_valid, arr_data,
    output m_valid, m_data
  );

  modport slave (
    output s_valid, s_data,
    output arr_psum_valid, arr_psum,
    output m_ready,
    input  s_ready, w_load, w_data,
    input  arr_en, arr_valid, arr_data,
    input  m_valid, m_data
  );

endinterface

// File: rtl/conv1d_out_reg.sv
// Result side: drops warm-up sums, holds one result, and
// stalls the array whenever that result is refused.
module conv1d_out_reg #(
  parameter int PSUM_WIDTH = conv1d_pkg::PSUM_WIDTH,
  parameter int LEN_WIDTH  = conv1d_pkg::LEN_WIDTH,
  parameter int K          = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr,
  input  logic                  i_psum_valid,
  input  logic [PSUM_WIDTH-1:0] i_psum,
  input  logic                  i_m_ready,
  output logic                  o_m_valid,
  output logic [PSUM_WIDTH-1:0] o_m_data,
  output logic                  o_arr_en,
  output logic [LEN_WIDTH-1:0]  o_kept
);

  logic                  r_m_valid;
  logic [PSUM_WIDTH-1:0] r_m_data;
  logic [LEN_WIDTH-1:0]  r_disc;
  logic [LEN_WIDTH-1:0]  r_kept;
  logic                  w_arr_en;
  logic                  w_beat;
  logic                  w_warm;

  assign w_arr_en = ~(r_m_valid & ~i_m_ready);
  assign w_beat   = i_psum_valid & w_arr_en;
  assign w_warm   = r_disc < LEN_WIDTH'(K-1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_disc    <= '0;
      r_kept    <= '0;
    end else if (i_clr) begin
      r_disc <= '0;
      r_kept <= '0;
    end else begin
      if (w_beat && w_warm)
        r_disc <= r_disc + LEN_WIDTH'(1);
      // A fresh load overrides a same-cycle handshake.
      if (w_beat && !w_warm) begin
        r_m_data  <= i_psum;
        r_m_valid <= 1'b1;
        r_kept    <= r_kept + LEN_WIDTH'(1);
      end else if (r_m_valid && i_m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign o_m_valid = r_m_valid;
  assign o_m_data  = r_m_data;
  assign o_arr_en  = w_arr_en;
  assign o_kept    = r_kept;

endmodule

// File: rtl/conv1d_seq_ctrl.sv
// Sequencer for the 1-D conv systolic array: weight load,
// sample streaming and result drain under one stall signal.
module conv1d_seq_ctrl #(
  parameter int DATA_WIDTH = conv1d_pkg::DATA_WIDTH,
  parameter int PSUM_WIDTH = conv1d_pkg::PSUM_WIDTH,
  parameter int K          = 3,
  parameter int LEN_WIDTH  = conv1d_pkg::LEN_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  conv1d_seq_ctrl_if.master    bus
);

  import conv1d_pkg::*;

  ctrl_state_t           r_state;
  ctrl_state_t           w_next;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_widx;
  logic [LEN_WIDTH-1:0]  r_scnt;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic [K-1:0]          r_w_load;
  logic [DATA_WIDTH-1:0] r_w_data;
  logic                  r_arr_valid;
  logic [DATA_WIDTH-1:0] r_arr_data;

  logic [MAX_K-1:0]      w_onehot;
  logic [LEN_WIDTH-1:0]  w_kept;
  logic                  w_m_valid;
  logic [PSUM_WIDTH-1:0] w_m_data;
  logic                  w_arr_en;
  logic                  w_idle;
  logic                  w_in_load;
  logic                  w_in_stream;
  logic                  w_start_ok;
  logic                  w_start_bad;
  logic                  w_s_ready;
  logic                  w_hs;
  logic                  w_drain_ok;

  assign w_idle      = r_state == S_IDLE;
  assign w_in_load   = r_state == S_LOAD_W;
  assign w_in_stream = r_state == S_STREAM;
  assign w_start_ok  = start & w_idle &
                       (len >= LEN_WIDTH'(K));
  assign w_start_bad = start & w_idle &
                       (len < LEN_WIDTH'(K));
  assign w_s_ready   = w_arr_en & (w_in_load | w_in_stream);
  assign w_hs        = bus.s_valid & w_s_ready;
  assign w_onehot    = onehot_k(r_widx);
  assign w_drain_ok  = (w_kept == r_len - LEN_WIDTH'(K-1)) &
                       (~w_m_valid | bus.m_ready);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_start_ok) w_next = S_LOAD_W;
      S_LOAD_W:
        if (w_hs && r_widx == LEN_WIDTH'(K-1))
          w_next = S_STREAM;
      S_STREAM:
        if (w_hs && r_scnt == r_len - LEN_WIDTH'(1))
          w_next = S_DRAIN;
      S_DRAIN:
        if (w_drain_ok) w_next = S_DONE;
      S_DONE:
        w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len       <= '0;
      r_widx      <= '0;
      r_scnt      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_w_load    <= '0;
      r_w_data    <= '0;
      r_arr_valid <= 1'b0;
      r_arr_data  <= '0;
    end else begin
      r_err  <= w_start_bad;
      r_done <= r_state == S_DONE;
      if (w_start_ok) begin
        r_busy <= 1'b1;
        r_len  <= len;
        r_widx <= '0;
        r_scnt <= '0;
      end else if (r_state == S_DONE) begin
        r_busy <= 1'b0;
      end
      // Array-facing strobes freeze with the rest of the array.
      if (w_arr_en) begin
        r_w_load    <= '0;
        r_arr_valid <= 1'b0;
        if (w_hs && w_in_load) begin
          r_w_load <= w_onehot[K-1:0];
          r_w_data <= bus.s_data;
          r_widx   <= r_widx + LEN_WIDTH'(1);
        end
        if (w_hs && w_in_stream) begin
          r_arr_valid <= 1'b1;
          r_arr_data  <= bus.s_data;
          r_scnt      <= r_scnt + LEN_WIDTH'(1);
        end
      end
    end
  end

  conv1d_out_reg #(
    .PSUM_WIDTH (PSUM_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH),
    .K          (K)
  ) u_out (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (w_start_ok),
    .i_psum_valid (bus.arr_psum_valid),
    .i_psum       (bus.arr_psum),
    .i_m_ready    (bus.m_ready),
    .o_m_valid    (w_m_valid),
    .o_m_data     (w_m_data),
    .o_arr_en     (w_arr_en),
    .o_kept       (w_kept)
  );

  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;
  assign bus.s_ready   = w_s_ready;
  assign bus.w_load    = r_w_load;
  assign bus.w_data    = r_w_data;
  assign bus.arr_en    = w_arr_en;
  assign bus.arr_valid = r_arr_valid;
  assign bus.arr_data  = r_arr_data;
  assign bus.m_valid   = w_m_valid;
  assign bus.m_data    = w_m_data;

endmodule
